dct_transpose_buf: RTL and testbench



---
 rtl/dct_transpose_buf_if.sv | 36 +++
 rtl/dct_transpose_buf.sv | 131 +++++++++++++
 tb/tb_dct_transpose_buf.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dct_transpose_buf_if.sv
// Stream interface for dct_transpose_buf: row-major input and column-major output handshakes.
// When DCT_TRANSPOSE_BYPASS_EN is defined, a per-block bypass input is added.
interface dct_transpose_buf_if #(
  parameter int DATA_WIDTH = 10
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_first;
  logic                  out_last;

`ifdef DCT_TRANSPOSE_BYPASS_EN
  logic                  bypass;

  modport slave (
    input  in_valid, in_data, bypass, out_ready,
    output in_ready, out_valid, out_data, out_first, out_last
  );
  modport master (
    output in_valid, in_data, bypass, out_ready,
    input  in_ready, out_valid, out_data, out_first, out_last
  );
`else
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_first, out_last
  );
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_first, out_last
  );
`endif
endinterface

// File: rtl/dct_transpose_buf.sv
// N x N ping-pong transpose buffer: accepts a block row-major and emits it column-major.
// Optional macro DCT_TRANSPOSE_BYPASS_EN adds a per-block bypass that keeps row-major order.
module dct_transpose_buf #(
  parameter int DATA_WIDTH = 10,
  parameter int N          = 8
) (
  input  logic               clk,
  input  logic               rst,
  dct_transpose_buf_if.slave bus
);
  localparam int DEPTH = N * N;
  localparam int AW    = $clog2(DEPTH);
  localparam int HW    = AW / 2;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_e;

  bank_state_e           r_state [2];
  logic                  r_wr_bank;
  logic                  r_rd_bank;
  logic [AW-1:0]         r_wr_idx;
  logic [AW-1:0]         r_rd_idx;
  logic [DATA_WIDTH-1:0] r_mem [2][DEPTH];
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_first;
  logic                  r_out_last;
`ifdef DCT_TRANSPOSE_BYPASS_EN
  logic                  r_bypass [2];
`endif

  logic          w_in_ready;
  logic          w_wr_fire;
  logic          w_advance;
  logic          w_rd_load;
  logic [AW-1:0] w_rd_addr;

  // Writer may only touch a bank the reader has released.
  assign w_in_ready = !rst && (r_state[r_wr_bank] == EMPTY || r_state[r_wr_bank] == FILLING);
  assign w_wr_fire  = bus.in_valid && w_in_ready;
  assign w_advance  = bus.out_ready || !r_out_valid;
  assign w_rd_load  = w_advance &&
                      (r_state[r_rd_bank] == FULL || r_state[r_rd_bank] == DRAINING);

  // k = col*N + row in reading order, so the stored address row*N + col is k with halves swapped.
  always_comb begin
    // NOTE: assign a default first so every path drives the signal and no latch is inferred.
    w_rd_addr = {r_rd_idx[HW-1:0], r_rd_idx[AW-1:HW]};
`ifdef DCT_TRANSPOSE_BYPASS_EN
    if (r_bypass[r_rd_bank]) begin
      w_rd_addr = r_rd_idx;
    end
`endif
  end

  // NOTE: sample storage is left out of reset; the bank states alone decide which words are live.
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      r_mem[r_wr_bank][r_wr_idx] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: all state uses <= so every update in this block sees the pre-edge values.
    if (rst) begin
      r_state[0]  <= EMPTY;
      r_state[1]  <= EMPTY;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_wr_idx    <= '0;
      r_rd_idx    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_first <= 1'b0;
      r_out_last  <= 1'b0;
`ifdef DCT_TRANSPOSE_BYPASS_EN
      r_bypass[0] <= 1'b0;
      r_bypass[1] <= 1'b0;
`endif
    end else begin
      // Writer and reader never act on the same bank in one cycle: their state sets are disjoint.
      if (w_wr_fire) begin
`ifdef DCT_TRANSPOSE_BYPASS_EN
        if (r_wr_idx == '0) begin
          r_bypass[r_wr_bank] <= bus.bypass;
        end
`endif
        if (r_wr_idx == LAST_IDX) begin
          r_state[r_wr_bank] <= FULL;
          r_wr_idx           <= '0;
          r_wr_bank          <= ~r_wr_bank;
        end else begin
          r_state[r_wr_bank] <= FILLING;
          r_wr_idx           <= r_wr_idx + AW'(1);
        end
      end

      if (w_advance) begin
        r_out_valid <= w_rd_load;
        if (w_rd_load) begin
          r_out_data  <= r_mem[r_rd_bank][w_rd_addr];
          r_out_first <= (r_rd_idx == '0);
          r_out_last  <= (r_rd_idx == LAST_IDX);
          if (r_rd_idx == LAST_IDX) begin
            r_state[r_rd_bank] <= EMPTY;
            r_rd_idx           <= '0;
            r_rd_bank          <= ~r_rd_bank;
          end else begin
            r_state[r_rd_bank] <= DRAINING;
            r_rd_idx           <= r_rd_idx + AW'(1);
          end
        end else begin
          r_out_first <= 1'b0;
          r_out_last  <= 1'b0;
        end
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_first = r_out_first;
  assign bus.out_last  = r_out_last;

endmodule

// File: tb/tb_dct_transpose_buf.sv
// Scoreboard bench for dct_transpose_buf: an 8x8/10-bit instance and a 4x4/12-bit instance.
module tb_dct_transpose_buf;
  localparam int DW8 = 10;
  localparam int N8  = 8;
  localparam int DW4 = 12;
  localparam int N4  = 4;

  typedef struct {
    int data;
    bit first;
    bit last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  exp_t q8[$];
  exp_t q4[$];
  exp_t e8;
  exp_t e4;
  int   g_stall;
  int   g_acc;
  int   gaps;
  int   wcnt;
  bit   prev_stall;
  int   prev_data;
  bit   prev_first;
  bit   prev_last;

  dct_transpose_buf_if #(.DATA_WIDTH(DW8)) b8 ();
  dct_transpose_buf_if #(.DATA_WIDTH(DW4)) b4 ();

  dct_transpose_buf #(.DATA_WIDTH(DW8), .N(N8)) dut8 (.clk(clk), .rst(rst), .bus(b8));
  dct_transpose_buf #(.DATA_WIDTH(DW4), .N(N4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected 8x8 output order: sample value is off + row*10 + col.
  task automatic push8(input int off, input bit byp);
    for (int k = 0; k < N8 * N8; k++) begin
      exp_t e;
      int   row;
      int   col;
      row    = byp ? k / N8 : k % N8;
      col    = byp ? k % N8 : k / N8;
      e.data  = off + row * 10 + col;
      e.first = (k == 0);
      e.last  = (k == N8 * N8 - 1);
      q8.push_back(e);
    end
  endtask

  task automatic push4();
    for (int k = 0; k < N4 * N4; k++) begin
      exp_t e;
      e.data  = -2048 + (k % N4) * N4 + (k / N4);
      e.first = (k == 0);
      e.last  = (k == N4 * N4 - 1);
      q4.push_back(e);
    end
  endtask

  task automatic send8(input int off, input int nsamp, input bit byp);
    for (int k = 0; k < nsamp; k++) begin
      int tries;
      bit hs;
      tries = 0;
      hs    = 1'b0;
      b8.in_valid = 1'b1;
      b8.in_data  = DW8'(off + (k / N8) * 10 + (k % N8));
`ifdef DCT_TRANSPOSE_BYPASS_EN
      b8.bypass = byp;
`endif
      while (!hs) begin
        @(negedge clk);
        hs = b8.in_ready;
        if (!hs) g_stall++;
        @(posedge clk);
        #1;
        tries++;
        if (!hs && tries > 2000) begin
          check("send8_timeout", tries, 0);
          b8.in_valid = 1'b0;
          return;
        end
      end
      g_acc++;
    end
    b8.in_valid = 1'b0;
    if (nsamp == N8 * N8) push8(off, byp);
  endtask

  task automatic send4();
    for (int k = 0; k < N4 * N4; k++) begin
      int tries;
      bit hs;
      tries = 0;
      hs    = 1'b0;
      b4.in_valid = 1'b1;
      b4.in_data  = DW4'(-2048 + k);
      while (!hs) begin
        @(negedge clk);
        hs = b4.in_ready;
        @(posedge clk);
        #1;
        tries++;
        if (!hs && tries > 2000) begin
          check("send4_timeout", tries, 0);
          b4.in_valid = 1'b0;
          return;
        end
      end
    end
    b4.in_valid = 1'b0;
    push4();
  endtask

  task automatic drain8();
    int n;
    n = 0;
    while (q8.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check("drain8_left", q8.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic drain4();
    int n;
    n = 0;
    while (q4.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check("drain4_left", q4.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor for the 8x8 instance: scoreboard pops plus hold-while-stalled checks.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid8", int'(b8.out_valid), 1);
        check("hold_data8", int'($signed(b8.out_data)), prev_data);
        check("hold_first8", int'(b8.out_first), int'(prev_first));
        check("hold_last8", int'(b8.out_last), int'(prev_last));
      end
      if (b8.out_valid && b8.out_ready) begin
        if (q8.size() == 0) begin
          check("unexpected_out8", int'($signed(b8.out_data)), -100000);
        end else begin
          e8 = q8.pop_front();
          check("data8", int'($signed(b8.out_data)), e8.data);
          check("first8", int'(b8.out_first), int'(e8.first));
          check("last8", int'(b8.out_last), int'(e8.last));
        end
      end
      prev_stall = b8.out_valid && !b8.out_ready;
      prev_data  = int'($signed(b8.out_data));
      prev_first = b8.out_first;
      prev_last  = b8.out_last;
    end
  end

  always @(negedge clk) begin
    if (!rst && b4.out_valid && b4.out_ready) begin
      if (q4.size() == 0) begin
        check("unexpected_out4", int'($signed(b4.out_data)), -100000);
      end else begin
        e4 = q4.pop_front();
        check("data4", int'($signed(b4.out_data)), e4.data);
        check("first4", int'(b4.out_first), int'(e4.first));
        check("last4", int'(b4.out_last), int'(e4.last));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    b8.in_valid  = 1'b0;
    b8.in_data   = '0;
    b8.out_ready = 1'b0;
    b4.in_valid  = 1'b0;
    b4.in_data   = '0;
    b4.out_ready = 1'b0;
`ifdef DCT_TRANSPOSE_BYPASS_EN
    b8.bypass    = 1'b0;
    b4.bypass    = 1'b0;
`endif
    g_stall = 0;
    g_acc   = 0;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready8", int'(b8.in_ready), 0);
    check("rst_out_valid8", int'(b8.out_valid), 0);
    check("rst_out_data8", int'(b8.out_data), 0);
    check("rst_out_first8", int'(b8.out_first), 0);
    check("rst_out_last8", int'(b8.out_last), 0);
    check("rst_in_ready4", int'(b4.in_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst8", int'(b8.in_ready), 1);
    check("in_ready_after_rst4", int'(b4.in_ready), 1);

    // Single block and first-output latency.
    @(posedge clk);
    #1;
    b8.out_ready = 1'b1;
    send8(0, 64, 1'b0);
    check("lat_edge_t", int'(b8.out_valid), 0);
    @(posedge clk);
    @(negedge clk);
    check("lat_edge_t1", int'(b8.out_valid), 1);
    drain8();

    // Three back-to-back blocks, no gaps and no in_ready drop.
    g_stall = 0;
    fork
      begin
        send8(0, 64, 1'b0);
        send8(100, 64, 1'b0);
        send8(200, 64, 1'b0);
      end
      begin
        wcnt = 0;
        do begin
          @(negedge clk);
          wcnt++;
        end while (!b8.out_valid && wcnt < 300);
        gaps = 0;
        repeat (191) begin
          @(negedge clk);
          if (!b8.out_valid) gaps++;
        end
      end
    join
    check("stream_gaps", gaps, 0);
    check("in_ready_drop", g_stall, 0);
    drain8();

    // Backpressure: 150 stalled cycles while three blocks are offered.
    b8.out_ready = 1'b0;
    g_acc = 0;
    fork
      begin
        send8(0, 64, 1'b0);
        send8(100, 64, 1'b0);
        send8(200, 64, 1'b0);
      end
      begin
        repeat (150) @(negedge clk);
        check("accepted_when_full", g_acc, 128);
        check("in_ready_when_full", int'(b8.in_ready), 0);
        @(posedge clk);
        #1;
        b8.out_ready = 1'b1;
      end
    join
    drain8();

    // Reset with a stalled output and a partial block in flight.
    b8.out_ready = 1'b0;
    send8(300, 64, 1'b0);
    send8(400, 20, 1'b0);
    @(negedge clk);
    check("pre_rst_valid", int'(b8.out_valid), 1);
    check("pre_rst_data", int'(b8.out_data), 300);
    @(posedge clk);
    #1;
    rst = 1'b1;
    q8.delete();
    @(posedge clk);
    repeat (2) begin
      @(negedge clk);
      check("mid_rst_in_ready", int'(b8.in_ready), 0);
      check("mid_rst_valid", int'(b8.out_valid), 0);
      check("mid_rst_data", int'(b8.out_data), 0);
      check("mid_rst_first", int'(b8.out_first), 0);
      check("mid_rst_last", int'(b8.out_last), 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    b8.out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", int'(b8.in_ready), 1);
    check("post_rst_valid", int'(b8.out_valid), 0);
    @(posedge clk);
    #1;
    send8(400, 64, 1'b0);
    drain8();

    // 4x4, 12-bit negative samples.
    b4.out_ready = 1'b1;
    send4();
    drain4();

`ifdef DCT_TRANSPOSE_BYPASS_EN
    // Bypassed block followed by a transposed block.
    send8(0, 64, 1'b1);
    send8(100, 64, 1'b0);
    drain8();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
